// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Bits needed to hold 0..div-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // Two-digit BCD increment; 99 rolls over to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = val[7:4];
        units = val[3:0];
        if (units == BCD_MAX_DIGIT) begin
            units = 4'd0;
            tens  = (tens == BCD_MAX_DIGIT) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for a raw push button.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // Next-state for the synchronizer chain and edge history.
    always_comb begin
        s1_d   = btn_in;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = s2_q & ~prev_q;

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/pause/zero stopwatch control with a two-digit count and display scan clock.
// Define HEX_COUNT_EN to count binary 00..FF instead of BCD 00..99.
module bcd_stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       GoBtn,
    input  logic       ZeroBtn,
    output logic [7:0] D,
    output logic       start,
    output logic       ScanCLK,
    output logic       Wrap
);

    localparam int unsigned TW = cnt_width(TICK_DIV);
    localparam int unsigned SW = cnt_width(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic go_pulse;
    logic zero_pulse;

    btn_sync_edge u_go_sync (
        .clk    (CLK),
        .rst    (CLR),
        .btn_in (GoBtn),
        .pulse  (go_pulse)
    );

    btn_sync_edge u_zero_sync (
        .clk    (CLK),
        .rst    (CLR),
        .btn_in (ZeroBtn),
        .pulse  (zero_pulse)
    );

    state_e        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] scan_q, scan_d;
    logic          scan_clk_q, scan_clk_d;
    logic          start_q, start_d;
    logic          wrap_q, wrap_d;
    logic [7:0]    count_inc;
    logic          count_at_max;

    // Next count value and rollover detection for the selected radix.
    always_comb begin
`ifdef HEX_COUNT_EN
        count_inc    = count_q + 8'd1;
        count_at_max = (count_q == 8'hFF);
`else
        count_inc    = bcd_inc(count_q);
        count_at_max = (count_q == {BCD_MAX_DIGIT, BCD_MAX_DIGIT});
`endif
    end

    // FSM, tick prescaler, counter and scan divider next-state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tick_d     = tick_q;
        wrap_d     = 1'b0;
        scan_d     = scan_q;
        scan_clk_d = scan_clk_q;

        case (state_q)
            ST_IDLE: begin
                if (go_pulse && !zero_pulse) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                end
            end
            ST_RUN: begin
                if (zero_pulse) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    tick_d  = '0;
                end else begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        count_d = count_inc;
                        wrap_d  = count_at_max;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                    if (go_pulse) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (zero_pulse) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    tick_d  = '0;
                end else if (go_pulse) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                tick_d  = '0;
            end
        endcase

        start_d = (state_d != ST_IDLE);

        if (scan_q == SCAN_LAST) begin
            scan_d     = '0;
            scan_clk_d = ~scan_clk_q;
        end else begin
            scan_d = scan_q + SW'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            tick_q     <= '0;
            scan_q     <= '0;
            scan_clk_q <= 1'b0;
            start_q    <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            scan_q     <= scan_d;
            scan_clk_q <= scan_clk_d;
            start_q    <= start_d;
            wrap_q     <= wrap_d;
        end
    end

    assign D       = count_q;
    assign start   = start_q;
    assign ScanCLK = scan_clk_q;
    assign Wrap    = wrap_q;

endmodule
